// File: rtl/dcmac_vl_marker_loader.sv
// Sequenced loader for the DCMAC TX virtual-lane marker IDs and VL length words.
// Walks every port on start and emits one config write per entry over a valid/ready channel.
module dcmac_vl_marker_loader #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned NUM_VL    = 20,
  parameter int unsigned LEN_100G  = 255,
  parameter int unsigned LEN_200G  = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NUM_PORTS-1:0] cfg_mode_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic                   wr_valid_o,
  input  logic                   wr_ready_i,
  output logic [2:0]             wr_port_o,
  output logic [4:0]             wr_idx_o,
  output logic                   wr_is_len_o,
  output logic [63:0]            wr_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   aborted_o,
  output logic                   cfg_err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_MARK,
    S_LEN,
    S_DONE
  } state_t;

  localparam logic [2:0]  LAST_PORT     = 3'(NUM_PORTS - 1);
  localparam logic [4:0]  LAST_IDX      = 5'(NUM_VL - 1);
  localparam logic [63:0] LEN_WORD_100G = 64'(LEN_100G);
  localparam logic [63:0] LEN_WORD_200G = 64'(LEN_200G);

  // Clause 82 lane markers: {M0,M1,M2,0x00,~M0,~M1,~M2,0x00}; only M0..M2 are stored.
  function automatic logic [63:0] vl_marker(input logic [4:0] idx);
    logic [23:0] m;
    case (idx)
      5'd0:    m = 24'hc16821;
      5'd1:    m = 24'h9d718e;
      5'd2:    m = 24'h594be8;
      5'd3:    m = 24'h4d957b;
      5'd4:    m = 24'hf50709;
      5'd5:    m = 24'hdd14c2;
      5'd6:    m = 24'h9a4a26;
      5'd7:    m = 24'h7b4566;
      5'd8:    m = 24'ha02476;
      5'd9:    m = 24'h68c9fb;
      5'd10:   m = 24'hfd6c99;
      5'd11:   m = 24'hb99155;
      5'd12:   m = 24'h5cb9b2;
      5'd13:   m = 24'h1af8bd;
      5'd14:   m = 24'h83c7ca;
      5'd15:   m = 24'h3536cd;
      5'd16:   m = 24'hc4314c;
      5'd17:   m = 24'hadd6b7;
      5'd18:   m = 24'h5f662a;
      5'd19:   m = 24'hc0f0e5;
      default: m = 24'h000000;
    endcase
    return {m, 8'h00, ~m, 8'h00};
  endfunction

  state_t                 state_q;
  logic [2*NUM_PORTS-1:0] mode_q;
  logic [2:0]             port_q;
  logic [4:0]             idx_q;
  logic                   wr_valid_q;
  logic                   wr_is_len_q;
  logic [63:0]            wr_data_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   aborted_q;
  logic                   cfg_err_q;

  logic [1:0]  port_mode;
  logic        port_illegal;
  logic        last_port;
  logic [63:0] len_word;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    port_mode = 2'b00;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (port_q == 3'(p)) port_mode = mode_q[2*p +: 2];
    end
    port_illegal = ((port_mode == 2'b11) && (port_q != 3'd0)) ||
                   ((port_mode == 2'b10) && port_q[0]);
    last_port    = (port_q == LAST_PORT);
    len_word     = (port_mode == 2'b01) ? LEN_WORD_100G : LEN_WORD_200G;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      port_q      <= '0;
      idx_q       <= '0;
      wr_valid_q  <= 1'b0;
      wr_is_len_q <= 1'b0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (abort_i && busy_q) begin
        // A handshake completing in this cycle has already been taken downstream.
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        wr_valid_q  <= 1'b0;
        wr_is_len_q <= 1'b0;
        idx_q       <= '0;
        aborted_q   <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              mode_q    <= cfg_mode_i;
              port_q    <= '0;
              idx_q     <= '0;
              cfg_err_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= S_SCAN;
            end
          end
          S_SCAN: begin
            if ((port_mode == 2'b00) || port_illegal) begin
              if (port_illegal) cfg_err_q <= 1'b1;
              if (last_port) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                port_q <= port_q + 3'd1;
              end
            end else begin
              state_q     <= S_MARK;
              idx_q       <= '0;
              wr_valid_q  <= 1'b1;
              wr_is_len_q <= 1'b0;
              wr_data_q   <= vl_marker(5'd0);
            end
          end
          S_MARK: begin
            if (wr_ready_i) begin
              if (idx_q == LAST_IDX) begin
                state_q     <= S_LEN;
                idx_q       <= '0;
                wr_is_len_q <= 1'b1;
                wr_data_q   <= len_word;
              end else begin
                idx_q     <= idx_q + 5'd1;
                wr_data_q <= vl_marker(idx_q + 5'd1);
              end
            end
          end
          S_LEN: begin
            if (wr_ready_i) begin
              wr_valid_q  <= 1'b0;
              wr_is_len_q <= 1'b0;
              if (last_port) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                port_q  <= port_q + 3'd1;
                state_q <= S_SCAN;
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign wr_valid_o  = wr_valid_q;
  assign wr_port_o   = port_q;
  assign wr_idx_o    = idx_q;
  assign wr_is_len_o = wr_is_len_q;
  assign wr_data_o   = wr_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign cfg_err_o   = cfg_err_q;

endmodule
